trainer_input_conditioner: RTL

- Input front-end for the digital trainer kit's gate array.
- Takes two raw, asynchronous push-button/switch inputs and synchronises and debounces them.
- Produces the clean operand pair a/b that drives the gate stage directly downstream.
- Four selectable operand modes: direct level, toggle latch, free-running truth-table auto-step, and manual single-step through the four input combinations.

---
 rtl/trainer_input_conditioner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/trainer_input_conditioner.sv
// Input front-end for the trainer gate array: synchronises and debounces two raw
// buttons and turns them into the operand pair a/b, using one of four operand modes.
module trainer_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_DIV        = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic [1:0] mode,
  output logic       a,
  output logic       b,
  output logic [1:0] step_idx,
  output logic       upd
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_SINGLE = 2'b11
  } mode_e;

  // Channel index 0 is button A, index 1 is button B.
  logic [1:0]    sync1, sync2;
  logic [1:0]    stable, stable_q, press;
  logic [CW-1:0] cnt [2];
  logic [1:0]    latch;
  logic [PW-1:0] presc;
  logic [1:0]    step;
  mode_e         mode_q;
  logic          mode_change;
  logic [1:0]    src_ab;
  logic [1:0]    ab;

  // Synchronisers run regardless of ena so a resume never sees a stale sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_b, btn_a};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable   <= '0;
      stable_q <= '0;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else if (ena) begin
      stable_q <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press       = stable & ~stable_q;
  assign mode_change = (mode != mode_q);

  // A mode change restarts the truth-table sequence; toggle latches survive it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= MODE_DIRECT;
      presc  <= '0;
      step   <= '0;
      latch  <= '0;
    end else if (ena) begin
      mode_q <= mode_e'(mode);
      if (mode_q == MODE_TOGGLE) begin
        latch <= latch ^ press;
      end
      if (mode_change) begin
        presc <= '0;
        step  <= '0;
      end else begin
        case (mode_q)
          MODE_AUTO: begin
            if (presc == PRESC_LAST) begin
              presc <= '0;
              step  <= step + 2'd1;
            end else begin
              presc <= presc + PW'(1);
            end
          end
          MODE_SINGLE: begin
            if (press[1]) begin
              step <= 2'd0;
            end else if (press[0]) begin
              step <= step + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    src_ab = {stable[0], stable[1]};
    case (mode_q)
      MODE_TOGGLE: src_ab = {latch[0], latch[1]};
      MODE_AUTO,
      MODE_SINGLE: src_ab = step;
      default:     src_ab = {stable[0], stable[1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ab  <= '0;
      upd <= 1'b0;
    end else if (ena) begin
      ab  <= src_ab;
      upd <= (src_ab != ab);
    end else begin
      upd <= 1'b0;
    end
  end

  assign a        = ab[1];
  assign b        = ab[0];
  assign step_idx = mode_q[1] ? step : 2'b00;

endmodule
